// File: rtl/uart_tx_pkg.sv
// Shared constants and FSM encoding for the UART transmitter.
package uart_tx_pkg;
    localparam int SIZEDATA     = 8;
    localparam int SB_TICK      = 16;
    localparam int PARITY_WIDTH = 1;
    localparam int OVERSAMPLE   = 16;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/uart_tx_if.sv
// Handshake/data bundle between a frame source and uart_tx.
interface uart_tx_if import uart_tx_pkg::*; #(
    parameter int DATA_W = SIZEDATA,
    parameter int PAR_W  = PARITY_WIDTH
);
    logic              i_tick;
    logic              i_tx_start;
    logic [DATA_W-1:0] i_tx_data;
    logic [PAR_W-1:0]  i_tx_parity;
    logic              o_tx;
    logic              o_tx_busy;
    logic              o_tx_done;

    modport master (
        output i_tick, i_tx_start, i_tx_data, i_tx_parity,
        input  o_tx, o_tx_busy, o_tx_done
    );
    modport slave (
        input  i_tick, i_tx_start, i_tx_data, i_tx_parity,
        output o_tx, o_tx_busy, o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, SIZEDATA data bits LSB first, one parity bit, stop.
// Bit timing comes from an external 16x oversampling tick.
module uart_tx #(
    parameter int SIZEDATA     = uart_tx_pkg::SIZEDATA,
    parameter int SB_TICK      = uart_tx_pkg::SB_TICK,
    parameter int PARITY_WIDTH = uart_tx_pkg::PARITY_WIDTH
) (
    input logic      i_clock,
    input logic      i_reset,
    uart_tx_if.slave bus
);
    import uart_tx_pkg::*;

    localparam int            BW        = (SIZEDATA > 1) ? $clog2(SIZEDATA) : 1;
    localparam logic [3:0]    TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SIZEDATA - 1);

    state_t                  state, state_n;
    logic [3:0]              tick_cnt, tick_n;
    logic [BW-1:0]           bit_cnt, bit_n;
    logic [SIZEDATA-1:0]     sh, sh_n, sh_shr;
    logic [PARITY_WIDTH-1:0] par, par_n;
    logic                    tx, tx_n;
    logic                    done;

    assign sh_shr = sh >> 1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            par      <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            sh       <= sh_n;
            par      <= par_n;
            tx       <= tx_n;
        end
    end

    // tx_n is the line level for the state being entered, so o_tx stays registered
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        sh_n    = sh;
        par_n   = par;
        tx_n    = tx;
        done    = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (bus.i_tx_start) begin
                    sh_n    = bus.i_tx_data;
                    par_n   = bus.i_tx_parity;
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: if (bus.i_tick) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_n  = '0;
                    state_n = DATA;
                    tx_n    = sh[0];
                end else tick_n = tick_cnt + 4'd1;
            end
            DATA: if (bus.i_tick) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_n = '0;
                    sh_n   = sh_shr;
                    bit_n  = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = PARITY;
                        tx_n    = par[0];
                    end else tx_n = sh_shr[0];
                end else tick_n = tick_cnt + 4'd1;
            end
            PARITY: if (bus.i_tick) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_n  = '0;
                    state_n = STOP;
                    tx_n    = 1'b1;
                end else tick_n = tick_cnt + 4'd1;
            end
            STOP: if (bus.i_tick) begin
                if (tick_cnt == STOP_LAST) begin
                    tick_n  = '0;
                    state_n = IDLE;
                    done    = 1'b1;
                end else tick_n = tick_cnt + 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.o_tx      = tx;
    assign bus.o_tx_busy = (state != IDLE);
    assign bus.o_tx_done = done;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, tick pacing, busy/restart behaviour, reset abort.
module tb_uart_tx;
    import uart_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic tx_s   [0:1023];
    logic busy_s [0:1023];
    logic done_s [0:1023];

    uart_tx_if bus();
    uart_tx dut (.i_clock(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    // Launches a frame on the next rising edge (caller sits just after a negedge),
    // then records outputs for cycles 1..n; cycle k lies between edge k-1 and edge k.
    task automatic capture(input logic [7:0] d, input logic p, input int n, input int div,
                           input int poke_at, input bit hold, input bit toggle);
        bus.i_tx_data   = d;
        bus.i_tx_parity = p;
        bus.i_tx_start  = 1'b1;
        bus.i_tick      = (div == 1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            bus.i_tx_start = hold || (k == poke_at);
            if (k == poke_at) bus.i_tx_data = 8'hFF;
            if (toggle) bus.i_tx_data = ~bus.i_tx_data;
            bus.i_tick = (k % div == 0);
            #1;
            tx_s[k]   = bus.o_tx;
            busy_s[k] = bus.o_tx_busy;
            done_s[k] = bus.o_tx_done;
        end
        bus.i_tx_start = 1'b0;
        bus.i_tick     = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_tx_start  = 1'b1;
        bus.i_tick      = 1'b1;
        bus.i_tx_data   = 8'h55;
        bus.i_tx_parity = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++; if (bus.o_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", bus.o_tx); end
            total++; if (bus.o_tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.o_tx_busy); end
            total++; if (bus.o_tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.o_tx_done); end
        end
        rst = 1'b0;
        bus.i_tx_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal();
        logic [10:0] ev = 11'b11000001100;  // 0x06, parity 1
        logic e;
        @(negedge clk);
        capture(8'h06, 1'b1, 180, 1, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 180; k++) begin
            e = (k <= 176) ? ev[(k-1)/16] : 1'b1;
            total++; if (tx_s[k] !== e) begin bad++; $display("FAIL normal_tx cyc=%0d got=%b exp=%b", k, tx_s[k], e); end
            total++; if (done_s[k] !== (k == 176)) begin bad++; $display("FAIL normal_done cyc=%0d got=%b exp=%b", k, done_s[k], k == 176); end
            total++; if (busy_s[k] !== (k <= 176)) begin bad++; $display("FAIL normal_busy cyc=%0d got=%b exp=%b", k, busy_s[k], k <= 176); end
        end
    endtask

    task automatic test_slow_tick();
        logic [10:0] ev = 11'b10101001010;  // 0xA5, parity 0
        logic e;
        @(negedge clk);
        capture(8'hA5, 1'b0, 712, 4, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 712; k++) begin
            e = (k <= 704) ? ev[(k-1)/64] : 1'b1;
            total++; if (tx_s[k] !== e) begin bad++; $display("FAIL slow_tx cyc=%0d got=%b exp=%b", k, tx_s[k], e); end
            total++; if (done_s[k] !== (k == 704)) begin bad++; $display("FAIL slow_done cyc=%0d got=%b exp=%b", k, done_s[k], k == 704); end
        end
    endtask

    task automatic test_busy_start();
        logic [10:0] ev = 11'b11000001100;
        logic e;
        @(negedge clk);
        capture(8'h06, 1'b1, 220, 1, 50, 1'b0, 1'b0);
        for (int k = 1; k <= 220; k++) begin
            e = (k <= 176) ? ev[(k-1)/16] : 1'b1;
            total++; if (tx_s[k] !== e) begin bad++; $display("FAIL busy_tx cyc=%0d got=%b exp=%b", k, tx_s[k], e); end
            total++; if (done_s[k] !== (k == 176)) begin bad++; $display("FAIL busy_done cyc=%0d got=%b exp=%b", k, done_s[k], k == 176); end
            total++; if (busy_s[k] !== (k <= 176)) begin bad++; $display("FAIL busy_busy cyc=%0d got=%b exp=%b", k, busy_s[k], k <= 176); end
        end
    endtask

    task automatic test_data_change();
        logic [10:0] ev = 11'b10001111000;  // 0x3C, parity 0
        logic e;
        @(negedge clk);
        capture(8'h3C, 1'b0, 180, 1, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 180; k++) begin
            e = (k <= 176) ? ev[(k-1)/16] : 1'b1;
            total++; if (tx_s[k] !== e) begin bad++; $display("FAIL change_tx cyc=%0d got=%b exp=%b", k, tx_s[k], e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] ev = 11'b11000001100;
        logic e;
        @(negedge clk);
        capture(8'h06, 1'b1, 360, 1, 0, 1'b1, 1'b0);
        for (int k = 1; k <= 360; k++) begin
            total++; if (done_s[k] !== (k == 176 || k == 353)) begin bad++; $display("FAIL b2b_done cyc=%0d got=%b", k, done_s[k]); end
        end
        for (int k = 178; k <= 353; k++) begin
            e = ev[(k-178)/16];
            total++; if (tx_s[k] !== e) begin bad++; $display("FAIL b2b_tx2 cyc=%0d got=%b exp=%b", k, tx_s[k], e); end
        end
        total++; if (tx_s[177] !== 1'b1) begin bad++; $display("FAIL b2b_gap_tx got=%b exp=1", tx_s[177]); end
        total++; if (busy_s[177] !== 1'b0) begin bad++; $display("FAIL b2b_gap_busy got=%b exp=0", busy_s[177]); end
        total++; if (busy_s[354] !== 1'b0) begin bad++; $display("FAIL b2b_gap2_busy got=%b exp=0", busy_s[354]); end
        repeat (200) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [10:0] ev = 11'b11100000010;  // 0x81, parity 1
        logic e;
        @(negedge clk);
        capture(8'h06, 1'b1, 79, 1, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 79; k++) begin
            total++; if (done_s[k] !== 1'b0) begin bad++; $display("FAIL rmid_pre_done cyc=%0d got=%b", k, done_s[k]); end
        end
        @(negedge clk);
        total++; if (bus.o_tx !== 1'b0) begin bad++; $display("FAIL rmid_pre_tx got=%b exp=0", bus.o_tx); end
        rst = 1'b1;
        #1;
        total++; if (bus.o_tx !== 1'b1) begin bad++; $display("FAIL rmid_tx got=%b exp=1", bus.o_tx); end
        total++; if (bus.o_tx_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.o_tx_busy); end
        total++; if (bus.o_tx_done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", bus.o_tx_done); end
        repeat (3) begin
            @(negedge clk);
            total++; if (bus.o_tx_done !== 1'b0) begin bad++; $display("FAIL rmid_hold_done got=%b exp=0", bus.o_tx_done); end
        end
        rst = 1'b0;
        capture(8'h81, 1'b1, 180, 1, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 180; k++) begin
            e = (k <= 176) ? ev[(k-1)/16] : 1'b1;
            total++; if (tx_s[k] !== e) begin bad++; $display("FAIL rmid_tx2 cyc=%0d got=%b exp=%b", k, tx_s[k], e); end
            total++; if (done_s[k] !== (k == 176)) begin bad++; $display("FAIL rmid_done2 cyc=%0d got=%b exp=%b", k, done_s[k], k == 176); end
            total++; if (busy_s[k] !== (k <= 176)) begin bad++; $display("FAIL rmid_busy2 cyc=%0d got=%b exp=%b", k, busy_s[k], k <= 176); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_slow_tick();
        test_busy_start();
        test_data_change();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
